// File: rtl/id_issue_queue_if.sv
// rtl/id_issue_queue_if.sv - decode-to-issue handshake bundle for id_issue_queue
interface id_issue_queue_if #(
  parameter int DATA_W = 64
) ();
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [DATA_W-1:0] enq_data_i;
  logic [31:0]       enq_orig_instr_i;
  logic              enq_is_ctrl_flow_i;
  logic              deq_valid_o;
  logic [DATA_W-1:0] deq_data_o;
  logic [31:0]       deq_orig_instr_o;
  logic              deq_is_ctrl_flow_o;
  logic              deq_ack_i;

  modport master (
    output enq_valid_i, enq_data_i, enq_orig_instr_i, enq_is_ctrl_flow_i, deq_ack_i,
    input  enq_ready_o, deq_valid_o, deq_data_o, deq_orig_instr_o, deq_is_ctrl_flow_o
  );

  modport slave (
    input  enq_valid_i, enq_data_i, enq_orig_instr_i, enq_is_ctrl_flow_i, deq_ack_i,
    output enq_ready_o, deq_valid_o, deq_data_o, deq_orig_instr_o, deq_is_ctrl_flow_o
  );
endinterface

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - circular-buffer queue of decoded entries between decode and issue
module id_issue_queue #(
  parameter int  DEPTH     = 2,
  parameter int  DATA_W    = 64,
  parameter bit  SINGLE_CF = 1'b0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  id_issue_queue_if.slave  q,
  output logic [CW-1:0]    count_o,
  output logic             cf_pending_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] data_mem  [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic [DEPTH-1:0]  cf_mem;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     count_q, cf_cnt_q;
  logic              head_valid, head_cf, cf_pending, cf_ok, fire, ack;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_q != '0);
  assign head_cf    = cf_mem[rd_ptr_q];
  assign cf_pending = (cf_cnt_q != '0);
  assign ack        = q.deq_ack_i & head_valid & !flush_i;

  // A second branch may enter only if the one already stored leaves this same cycle.
  always_comb begin
    cf_ok = 1'b1;
    if (SINGLE_CF)
      cf_ok = !(q.enq_is_ctrl_flow_i & cf_pending & !(q.deq_ack_i & head_valid & head_cf));
  end

  assign q.enq_ready_o = !flush_i & ((count_q < CW'(DEPTH)) | (q.deq_ack_i & head_valid)) & cf_ok;
  assign fire          = q.enq_valid_i & q.enq_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cf_cnt_q <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cf_cnt_q <= '0;
    end else begin
      if (fire) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (ack)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q  <= count_q + CW'(fire) - CW'(ack);
      cf_cnt_q <= cf_cnt_q + CW'(fire & q.enq_is_ctrl_flow_i) - CW'(ack & head_cf);
    end
  end

  // Payload storage carries no reset; contents are only observed while counted valid.
  always_ff @(posedge clk_i) begin
    if (fire) begin
      data_mem[wr_ptr_q]  <= q.enq_data_i;
      instr_mem[wr_ptr_q] <= q.enq_orig_instr_i;
      cf_mem[wr_ptr_q]    <= q.enq_is_ctrl_flow_i;
    end
  end

  assign q.deq_valid_o        = head_valid;
  assign q.deq_data_o         = data_mem[rd_ptr_q];
  assign q.deq_orig_instr_o   = instr_mem[rd_ptr_q];
  assign q.deq_is_ctrl_flow_o = head_cf;
  assign count_o              = count_q;
  assign cf_pending_o         = cf_pending;

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - self-checking bench for id_issue_queue at DEPTH 4, 1 and 3
module tb_id_issue_queue;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_a, flush_b, flush_c;
  logic [2:0] cnt_a;
  logic [0:0] cnt_b;
  logic [1:0] cnt_c;
  logic cfp_a, cfp_b, cfp_c;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_issue_queue_if #(.DATA_W(16)) ia ();
  id_issue_queue_if #(.DATA_W(16)) ib ();
  id_issue_queue_if #(.DATA_W(16)) ic ();

  id_issue_queue #(.DEPTH(4), .DATA_W(16), .SINGLE_CF(1'b1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_a), .q(ia), .count_o(cnt_a), .cf_pending_o(cfp_a));
  id_issue_queue #(.DEPTH(1), .DATA_W(16), .SINGLE_CF(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_b), .q(ib), .count_o(cnt_b), .cf_pending_o(cfp_b));
  id_issue_queue #(.DEPTH(3), .DATA_W(16), .SINGLE_CF(1'b0)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_c), .q(ic), .count_o(cnt_c), .cf_pending_o(cfp_c));

  typedef struct {
    logic        fl, v, cf, ack;
    logic [15:0] d;
    logic        rdy;
    logic [2:0]  cnt;
    logic        dv;
    logic [15:0] dd;
    logic        cfp;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic fl, logic v, logic [15:0] d, logic cf, logic ack,
                              logic rdy, logic [2:0] cnt, logic dv, logic [15:0] dd, logic cfp);
    vec_t r;
    r.fl = fl; r.v = v; r.d = d; r.cf = cf; r.ack = ack;
    r.rdy = rdy; r.cnt = cnt; r.dv = dv; r.dd = dd; r.cfp = cfp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic fl, input logic v, input logic [15:0] d, input logic cf, input logic ack);
    flush_a               = fl;
    ia.enq_valid_i        = v;
    ia.enq_data_i         = d;
    ia.enq_orig_instr_i   = {16'hC0DE, d};
    ia.enq_is_ctrl_flow_i = cf;
    ia.deq_ack_i          = ack;
  endtask

  logic [15:0] mq[$];
  int sent, rcvd, cfm;
  logic vc, ac, exp_rdy, take_enq, take_deq;

  initial begin
    rst_n = 1'b0;
    flush_b = 1'b0; flush_c = 1'b0;
    drive_a(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    ib.enq_valid_i = 1'b0; ib.enq_data_i = '0; ib.enq_orig_instr_i = '0;
    ib.enq_is_ctrl_flow_i = 1'b0; ib.deq_ack_i = 1'b0;
    ic.enq_valid_i = 1'b0; ic.enq_data_i = '0; ic.enq_orig_instr_i = '0;
    ic.enq_is_ctrl_flow_i = 1'b0; ic.deq_ack_i = 1'b0;

    // fl v  d  cf ack | rdy cnt dv dd cfp
    tv.push_back(mk(0, 1, 16'h00A1, 0, 0, 1, 1, 1, 16'h00A1, 0));
    tv.push_back(mk(0, 1, 16'h00B2, 0, 0, 1, 2, 1, 16'h00A1, 0));
    tv.push_back(mk(0, 1, 16'h00C3, 0, 0, 1, 3, 1, 16'h00A1, 0));
    tv.push_back(mk(0, 1, 16'h00D4, 0, 0, 1, 4, 1, 16'h00A1, 0));
    tv.push_back(mk(0, 1, 16'h00E5, 0, 0, 0, 4, 1, 16'h00A1, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 3, 1, 16'h00B2, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 2, 1, 16'h00C3, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h00D4, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 0));
    tv.push_back(mk(0, 1, 16'h0011, 0, 0, 1, 1, 1, 16'h0011, 0));
    tv.push_back(mk(0, 1, 16'h0012, 0, 0, 1, 2, 1, 16'h0011, 0));
    tv.push_back(mk(0, 1, 16'h0013, 1, 0, 1, 3, 1, 16'h0011, 1));
    tv.push_back(mk(1, 1, 16'h0014, 0, 1, 0, 0, 0, 16'h0000, 0));
    tv.push_back(mk(0, 1, 16'h0015, 0, 0, 1, 1, 1, 16'h0015, 0));
    tv.push_back(mk(0, 1, 16'h00B1, 1, 1, 1, 1, 1, 16'h00B1, 1));
    tv.push_back(mk(0, 1, 16'h00B2, 1, 0, 0, 1, 1, 16'h00B1, 1));
    tv.push_back(mk(0, 1, 16'h00B2, 1, 1, 1, 1, 1, 16'h00B2, 1));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 0));
    tv.push_back(mk(0, 1, 16'h00B3, 1, 0, 1, 1, 1, 16'h00B3, 1));
    tv.push_back(mk(0, 1, 16'h00C4, 0, 0, 1, 2, 1, 16'h00B3, 1));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 1, 1, 16'h00C4, 0));
    tv.push_back(mk(0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count_a", 32'(cnt_a), 0);
    chk("rst_valid_a", 32'(ia.deq_valid_o), 0);
    chk("rst_cfp_a", 32'(cfp_a), 0);
    chk("rst_valid_b", 32'(ib.deq_valid_o), 0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      drive_a(tv[i].fl, tv[i].v, tv[i].d, tv[i].cf, tv[i].ack);
      @(negedge clk);
      chk($sformatf("a%0d_ready", i), 32'(ia.enq_ready_o), 32'(tv[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("a%0d_count", i), 32'(cnt_a), 32'(tv[i].cnt));
      chk($sformatf("a%0d_valid", i), 32'(ia.deq_valid_o), 32'(tv[i].dv));
      chk($sformatf("a%0d_cfp", i), 32'(cfp_a), 32'(tv[i].cfp));
      if (tv[i].dv) begin
        chk($sformatf("a%0d_data", i), 32'(ia.deq_data_o), 32'(tv[i].dd));
        chk($sformatf("a%0d_instr", i), ia.deq_orig_instr_o, {16'hC0DE, tv[i].dd});
      end
    end

    // async reset with two entries held, then first enqueue after release
    drive_a(1'b0, 1'b1, 16'h0031, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b0, 1'b1, 16'h0032, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(cnt_a), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(cnt_a), 0);
    chk("async_rst_valid", 32'(ia.deq_valid_o), 0);
    chk("async_rst_cfp", 32'(cfp_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_a(1'b0, 1'b1, 16'h0039, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_ready", 32'(ia.enq_ready_o), 1);
    @(posedge clk); #1;
    drive_a(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("post_rst_count", 32'(cnt_a), 1);
    chk("post_rst_data", 32'(ia.deq_data_o), 32'h39);

    // DEPTH=1: full-and-acked accepts every cycle
    ib.enq_valid_i = 1'b1; ib.enq_data_i = 16'h0100;
    @(negedge clk);
    chk("b_first_ready", 32'(ib.enq_ready_o), 1);
    @(posedge clk); #1;
    chk("b_first_count", 32'(cnt_b), 1);
    ib.enq_data_i = 16'h0101;
    @(negedge clk);
    chk("b_full_ready", 32'(ib.enq_ready_o), 0);
    @(posedge clk); #1;
    chk("b_full_data", 32'(ib.deq_data_o), 32'h100);
    for (int i = 0; i < 6; i++) begin
      ib.deq_ack_i = 1'b1;
      ib.enq_data_i = 16'(16'h0101 + i);
      @(negedge clk);
      chk($sformatf("b%0d_ready", i), 32'(ib.enq_ready_o), 1);
      chk($sformatf("b%0d_head", i), 32'(ib.deq_data_o), 32'(16'h0100 + i));
      @(posedge clk); #1;
      chk($sformatf("b%0d_count", i), 32'(cnt_b), 1);
      chk($sformatf("b%0d_next", i), 32'(ib.deq_data_o), 32'(16'h0101 + i));
    end
    ib.enq_valid_i = 1'b0;
    @(posedge clk); #1;
    ib.deq_ack_i = 1'b0;
    chk("b_drain_valid", 32'(ib.deq_valid_o), 0);

    // DEPTH=3: seven entries through a stalling producer/consumer, pointers wrap twice
    sent = 0; rcvd = 0; cfm = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      vc = (sent < 7) && (cyc % 4 != 3);
      ac = (cyc >= 2) && (cyc % 3 != 1);
      ic.enq_valid_i = vc;
      ic.enq_data_i = 16'(16'h0300 + sent);
      ic.enq_orig_instr_i = 32'(sent);
      ic.enq_is_ctrl_flow_i = sent[0];
      ic.deq_ack_i = ac;
      @(negedge clk);
      exp_rdy = (mq.size() < 3) || (ac && mq.size() > 0);
      chk($sformatf("c%0d_ready", cyc), 32'(ic.enq_ready_o), 32'(exp_rdy));
      take_deq = ac && (mq.size() > 0);
      take_enq = vc && exp_rdy;
      if (take_deq) chk($sformatf("c%0d_head", cyc), 32'(ic.deq_data_o), 32'(mq[0]));
      @(posedge clk); #1;
      if (take_deq) begin
        if (mq[0][0]) cfm--;
        void'(mq.pop_front());
        rcvd++;
      end
      if (take_enq) begin
        mq.push_back(16'(16'h0300 + sent));
        if (sent[0]) cfm++;
        sent++;
      end
      chk($sformatf("c%0d_count", cyc), 32'(cnt_c), 32'(mq.size()));
      chk($sformatf("c%0d_cfp", cyc), 32'(cfp_c), 32'(cfm != 0));
    end
    ic.enq_valid_i = 1'b0; ic.deq_ack_i = 1'b0;
    chk("c_received", 32'(rcvd), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
